bht_satcnt: RTL and testbench



---
 rtl/ariane_pkg.sv | 22 ++
 rtl/bht_satcnt_sat_counter.sv | 28 ++
 rtl/bht_satcnt.sv | 161 ++++++++++++++++
 tb/tb_bht_satcnt.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared frontend types and constants for the saturating-counter BHT.
// Optional BHT_GSHARE_EN in bht_satcnt folds global history into the row index.
package ariane_pkg;

    localparam int unsigned INSTR_PER_FETCH = 2;
    localparam int unsigned BHT_CTR_BITS = 2;

    typedef struct packed {
        logic                    valid;
        logic [BHT_CTR_BITS-1:0] ctr;
    } bht_entry_t;

    localparam logic [BHT_CTR_BITS-1:0] BHT_CTR_MAX = '1;
    localparam logic [BHT_CTR_BITS-1:0] BHT_WEAK_NT = BHT_CTR_MAX >> 1;
    localparam logic [BHT_CTR_BITS-1:0] BHT_WEAK_T = BHT_CTR_MAX ^ BHT_WEAK_NT;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_e;

endpackage

// File: rtl/bht_satcnt_sat_counter.sv
// Next-entry logic for one BHT counter: weak init on first use, then
// saturating increment/decrement.
module sat_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             valid,
    input  logic [WIDTH-1:0] ctr,
    input  logic             taken,
    output logic             nxt_valid,
    output logic [WIDTH-1:0] nxt_ctr
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] WEAK_NT = MAX >> 1;
    localparam logic [WIDTH-1:0] WEAK_T = MAX ^ WEAK_NT;

    always_comb begin
        nxt_valid = 1'b1;
        nxt_ctr   = ctr;
        unique case (1'b1)
            !valid: nxt_ctr = taken ? WEAK_T : WEAK_NT;
            valid && taken: nxt_ctr = (ctr == MAX) ? ctr : ctr + 1'b1;
            valid && !taken: nxt_ctr = (ctr == '0) ? ctr : ctr - 1'b1;
            default: nxt_ctr = ctr;
        endcase
    end

endmodule

// File: rtl/bht_satcnt.sv
// Saturating-counter branch history table with row-by-row clear sequencing.
// Define BHT_GSHARE_EN to XOR a global history register into the row index.
module bht_satcnt #(
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned INSTR_PER_FETCH = ariane_pkg::INSTR_PER_FETCH,
    parameter int unsigned CTR_BITS        = ariane_pkg::BHT_CTR_BITS,
    parameter int unsigned VLEN            = 64,
    parameter int unsigned HIST_BITS       = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       update_valid_i,
    input  logic [VLEN-1:0]            update_pc_i,
    input  logic                       update_taken_i,
    output logic [INSTR_PER_FETCH-1:0] bht_valid_o,
    output logic [INSTR_PER_FETCH-1:0] bht_taken_o,
    output logic                       flush_busy_o
);

    import ariane_pkg::*;

    localparam int unsigned NR_ROWS = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
    localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);
    localparam int unsigned TOP = ROW_BITS + COL_BITS;

    typedef struct packed {
        logic                valid;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    typedef entry_t [INSTR_PER_FETCH-1:0] row_t;

    row_t mem [NR_ROWS];
    row_t rd_data;
    row_t rd_q;

    clr_state_e state;
    logic [ROW_BITS-1:0] clr_ptr;
    logic busy;

    logic [ROW_BITS-1:0] rd_row;
    logic [ROW_BITS-1:0] wr_row;
    logic [COL_BITS-1:0] wr_col;
    logic accept;
    entry_t cur;
    entry_t nxt;

`ifdef BHT_GSHARE_EN
    logic [HIST_BITS-1:0] ghr;
    logic [ROW_BITS-1:0] hash;

    assign hash = ROW_BITS'(ghr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr <= '0;
        end else if (accept) begin
            ghr <= {ghr[HIST_BITS-2:0], update_taken_i};
        end
    end
`else
    logic [ROW_BITS-1:0] hash;
    logic unused_hist;

    assign hash = '0;
    assign unused_hist = ^(32'(HIST_BITS));
`endif

    logic unused_pc;
    assign unused_pc = ^{vpc_i[VLEN-1:TOP+1], vpc_i[0],
                         update_pc_i[VLEN-1:TOP+1], update_pc_i[0]};

    assign busy = (state == CLEAR);
    assign flush_busy_o = busy;

    assign rd_row = vpc_i[TOP:COL_BITS+1] ^ hash;
    assign wr_row = update_pc_i[TOP:COL_BITS+1] ^ hash;
    assign wr_col = update_pc_i[COL_BITS:1];

    assign accept = update_valid_i & ~debug_mode_i & ~busy & ~rst_i;
    assign cur = mem[wr_row][wr_col];

    sat_counter #(
        .WIDTH(CTR_BITS)
    ) u_ctr (
        .valid    (cur.valid),
        .ctr      (cur.ctr),
        .taken    (update_taken_i),
        .nxt_valid(nxt.valid),
        .nxt_ctr  (nxt.ctr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush_i) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
                CLEAR: begin
                    if (flush_i) begin
                        clr_ptr <= '0;
                    end else if (clr_ptr == ROW_BITS'(NR_ROWS - 1)) begin
                        state   <= IDLE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (busy) begin
            mem[clr_ptr] <= '0;
        end else if (accept) begin
            mem[wr_row][wr_col] <= nxt;
        end
    end

    // The registered read sees this edge's clear or update of the same row.
    always_comb begin
        rd_data = mem[rd_row];
        if (busy && (rd_row == clr_ptr)) begin
            rd_data = '0;
        end
        if (accept && (rd_row == wr_row)) begin
            rd_data[wr_col] = nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_data;
        end
    end

    always_comb begin
        for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            bht_valid_o[i] = ~busy & rd_q[i].valid;
            bht_taken_o[i] = ~busy & rd_q[i].valid & rd_q[i].ctr[CTR_BITS-1];
        end
    end

endmodule

// File: tb/tb_bht_satcnt.sv
// Directed plus random checks of bht_satcnt against a table-of-counters model.
module tb_bht_satcnt;

    localparam int NR = 16;
    localparam int IPF = 2;
    localparam int ROWS = NR / IPF;
    localparam int CB = 2;
    localparam int HB = 3;
    localparam int CMAX = (1 << CB) - 1;
    localparam int CHALF = 1 << (CB - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic dbg = 1'b0;
    logic [63:0] vpc = '0;
    logic uv = 1'b0;
    logic [63:0] upc = '0;
    logic ut = 1'b0;
    logic [IPF-1:0] valid_o;
    logic [IPF-1:0] taken_o;
    logic busy_o;

    int checks = 0;
    int failures = 0;

    int mctr [NR];
    bit mvld [NR];
    int busy_rem = 0;
    int ghr = 0;

    always #5 clk = ~clk;

    bht_satcnt #(
        .NR_ENTRIES     (NR),
        .INSTR_PER_FETCH(IPF),
        .CTR_BITS       (CB),
        .VLEN           (64),
        .HIST_BITS      (HB)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .debug_mode_i  (dbg),
        .vpc_i         (vpc),
        .update_valid_i(uv),
        .update_pc_i   (upc),
        .update_taken_i(ut),
        .bht_valid_o   (valid_o),
        .bht_taken_o   (taken_o),
        .flush_busy_o  (busy_o)
    );

    function automatic int row_of(input logic [63:0] pc);
        int r;
        r = int'((pc >> 2) % ROWS);
`ifdef BHT_GSHARE_EN
        r = r ^ (ghr % (1 << HB));
`endif
        return r;
    endfunction

    function automatic int col_of(input logic [63:0] pc);
        return int'((pc >> 1) % IPF);
    endfunction

    task automatic wipe();
        for (int k = 0; k < NR; k++) begin
            mctr[k] = 0;
            mvld[k] = 1'b0;
        end
    endtask

    task automatic step(input logic [63:0] v, input bit u,
                        input logic [63:0] p, input bit t,
                        input bit f, input bit d, input bit r);
        bit acc;
        int lrow;
        int idx;
        logic [IPF-1:0] ev;
        logic [IPF-1:0] et;
        logic eb;
        vpc = v;
        uv = u;
        upc = p;
        ut = t;
        flush = f;
        dbg = d;
        rst = r;
        @(posedge clk);
        acc = u && !d && (busy_rem == 0) && !r;
        lrow = row_of(v);
        idx = row_of(p) * IPF + col_of(p);
        if (acc) begin
            if (!mvld[idx]) begin
                mvld[idx] = 1'b1;
                mctr[idx] = t ? CHALF : CHALF - 1;
            end else if (t) begin
                mctr[idx] = (mctr[idx] + 1 > CMAX) ? CMAX : mctr[idx] + 1;
            end else begin
                mctr[idx] = (mctr[idx] - 1 < 0) ? 0 : mctr[idx] - 1;
            end
            ghr = ((ghr << 1) | int'(t)) % (1 << HB);
        end
        if (r) begin
            busy_rem = ROWS;
            ghr = 0;
            wipe();
        end else if (f) begin
            busy_rem = ROWS;
            wipe();
        end else if (busy_rem > 0) begin
            busy_rem--;
        end
        eb = (busy_rem > 0);
        for (int i = 0; i < IPF; i++) begin
            ev[i] = !eb && mvld[lrow * IPF + i];
            et[i] = ev[i] && (mctr[lrow * IPF + i] >= CHALF);
        end
        #1;
        checks++;
        assert (busy_o === eb) else begin
            failures++;
            $error("FAIL busy obs=%b exp=%b", busy_o, eb);
        end
        checks++;
        assert (valid_o === ev) else begin
            failures++;
            $error("FAIL valid vpc=%h obs=%b exp=%b", v, valid_o, ev);
        end
        checks++;
        assert (taken_o === et) else begin
            failures++;
            $error("FAIL taken vpc=%h obs=%b exp=%b", v, taken_o, et);
        end
    endtask

    task automatic idle(input logic [63:0] v);
        step(v, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [63:0] v, input logic [63:0] p, input bit t);
        step(v, 1'b1, p, t, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = busy_o ? 1 : 0;
        for (int k = 0; k < 20 && busy_o; k++) begin
            step(64'h400, 1'b1, 64'h400, 1'b1, 1'b0, 1'b0, 1'b0);
            if (busy_o) n++;
        end
        checks++;
        assert (n === ROWS) else begin
            failures++;
            $error("FAIL %s_len obs=%0d exp=%0d", tag, n, ROWS);
        end
    endtask

    initial begin
        wipe();
        step(64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(64'h0, 1'b1, 64'h104, 1'b1, 1'b0, 1'b0, 1'b1);
        count_busy("reset");
        idle(64'h104);

        upd(64'h0, 64'h104, 1'b1);
        idle(64'h104);
        upd(64'h104, 64'h104, 1'b0);
        upd(64'h104, 64'h104, 1'b0);
        upd(64'h104, 64'h104, 1'b0);
        upd(64'h104, 64'h104, 1'b1);
        idle(64'h104);
        upd(64'h104, 64'h104, 1'b1);
        upd(64'h104, 64'h104, 1'b1);
        idle(64'h104);

        for (int k = 0; k < 4; k++) upd(64'h200, 64'h200, 1'b1);
        upd(64'h200, 64'h200, 1'b0);
        upd(64'h200, 64'h200, 1'b0);
        upd(64'h200, 64'h200, 1'b0);

        upd(64'h30C, 64'h30C, 1'b0);
        upd(64'h30E, 64'h30E, 1'b1);
        idle(64'h30C);

        step(64'h104, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(64'h104);
        idle(64'h104);
        step(64'h104, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        count_busy("flush");
        idle(64'h400);
        idle(64'h104);

        upd(64'h104, 64'h104, 1'b1);
        step(64'h104, 1'b1, 64'h104, 1'b0, 1'b0, 1'b1, 1'b0);
        step(64'h104, 1'b1, 64'h104, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(64'h104);
        upd(64'h104, 64'h10C, 1'b1);
        upd(64'h104, 64'h104, 1'b1);
        idle(64'h104);

        for (int k = 0; k < 600; k++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = 64'($urandom_range(0, 63)) << 1;
            b = ($urandom_range(0, 3) == 0) ? a : 64'($urandom_range(0, 63)) << 1;
            step(a, 1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 249) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
